// File: rtl/demux_pkt_router_pkg.sv
// Shared types and constants for the packet router: FSM encoding, header layout and default widths.
package demux_pkt_router_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRoute   = 2'b01,
        StDiscard = 2'b10
    } state_e;

    localparam int unsigned HdrSelBit = 0;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefCntW   = 8;
    localparam int unsigned DefMaxLen = 16;
    // Wide enough for any legal MAX_LEN (up to 2^16-1).
    localparam int unsigned LenW      = 16;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register steering its beat onto one of two valid/ready channels;
// the unselected channel is driven to zero.
module demux_out_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              sel_i,
    input  logic              y0_ready_i,
    input  logic              y1_ready_i,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic              out_sel_o,
    output logic              out_ready_o,
    output logic [DATA_W-1:0] y0_data_o,
    output logic              y0_valid_o,
    output logic              y0_last_o,
    output logic [DATA_W-1:0] y1_data_o,
    output logic              y1_valid_o,
    output logic              y1_last_o
);

    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign out_ready_o = sel_q ? y1_ready_i : y0_ready_i;

    // A load in the same cycle as a drain simply overwrites the entry, so there is no bubble.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            sel_d   = sel_i;
            data_d  = data_i;
        end else if (valid_q && out_ready_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign out_sel_o   = sel_q;

    assign y0_valid_o = valid_q & ~sel_q;
    assign y1_valid_o = valid_q & sel_q;
    assign y0_data_o  = data_q & {DATA_W{y0_valid_o}};
    assign y1_data_o  = data_q & {DATA_W{y1_valid_o}};
    assign y0_last_o  = last_q & y0_valid_o;
    assign y1_last_o  = last_q & y1_valid_o;

endmodule

// File: rtl/demux_pkt_router.sv
// Packet-level 1-to-2 demultiplexer: header bit selects the output channel, payload is forwarded
// through a single register; per-channel packet counters and length/header error flags.
module demux_pkt_router
    import demux_pkt_router_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned MAX_LEN = DefMaxLen
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] y0_data,
    output logic              y0_valid,
    output logic              y0_last,
    input  logic              y0_ready,
    output logic [DATA_W-1:0] y1_data,
    output logic              y1_valid,
    output logic              y1_last,
    input  logic              y1_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              err_len,
    output logic              err_hdr
);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              err_len_q, err_len_d;
    logic              err_hdr_q, err_hdr_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              ready_c;
    logic              load;
    logic              load_last;
    logic              at_max;
    logic              out_valid, out_last, out_sel, out_ready;

    assign at_max = (len_q == LenW'(MAX_LEN - 1));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        err_len_d = err_len_q;
        err_hdr_d = 1'b0;
        ready_c   = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    sel_d = in_data[HdrSelBit];
                    len_d = '0;
                    // Header-only packets are dropped and flagged, never counted.
                    if (in_last) begin
                        err_hdr_d = 1'b1;
                    end else begin
                        state_d = StRoute;
                    end
                end
            end
            StRoute: begin
                ready_c = ~out_valid | out_ready;
                if (in_valid && ready_c) begin
                    load      = 1'b1;
                    load_last = in_last | at_max;
                    len_d     = len_q + LenW'(1);
                    if (in_last) begin
                        state_d = StIdle;
                    end else if (at_max) begin
                        err_len_d = 1'b1;
                        state_d   = StDiscard;
                    end
                end
            end
            StDiscard: begin
                ready_c = 1'b1;
                if (in_valid && in_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out_valid && out_last && out_ready) begin
            if (out_sel) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            len_q     <= '0;
            err_len_q <= 1'b0;
            err_hdr_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            err_len_q <= err_len_d;
            err_hdr_q <= err_hdr_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    demux_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .data_i     (in_data),
        .last_i     (load_last),
        .sel_i      (sel_q),
        .y0_ready_i (y0_ready),
        .y1_ready_i (y1_ready),
        .out_valid_o(out_valid),
        .out_last_o (out_last),
        .out_sel_o  (out_sel),
        .out_ready_o(out_ready),
        .y0_data_o  (y0_data),
        .y0_valid_o (y0_valid),
        .y0_last_o  (y0_last),
        .y1_data_o  (y1_data),
        .y1_valid_o (y1_valid),
        .y1_last_o  (y1_last)
    );

    assign in_ready = ready_c & ~rst;
    assign busy     = (state_q != StIdle) | out_valid;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign err_len  = err_len_q;
    assign err_hdr  = err_hdr_q;

endmodule

// File: tb/tb_demux_pkt_router.sv
// Directed, table-driven bench for demux_pkt_router (MAX_LEN=4) plus a mid-packet reset sequence.
module tb_demux_pkt_router;

    typedef struct packed {
        logic       ir;
        logic       bz;
        logic       y0v;
        logic [7:0] y0d;
        logic       y0l;
        logic       y1v;
        logic [7:0] y1d;
        logic       y1l;
        logic [7:0] c0;
        logic [7:0] c1;
        logic       eh;
        logic       el;
    } out_t;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       l;
        logic       r0;
        logic       r1;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] y0_data, y1_data;
    logic       y0_valid, y0_last, y1_valid, y1_last;
    logic       y0_ready = 1'b1;
    logic       y1_ready = 1'b1;
    logic       busy;
    logic [7:0] pkt_cnt0, pkt_cnt1;
    logic       err_len, err_hdr;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    demux_pkt_router #(
        .DATA_W (8),
        .CNT_W  (8),
        .MAX_LEN(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .y0_data (y0_data),
        .y0_valid(y0_valid),
        .y0_last (y0_last),
        .y0_ready(y0_ready),
        .y1_data (y1_data),
        .y1_valid(y1_valid),
        .y1_last (y1_last),
        .y1_ready(y1_ready),
        .busy    (busy),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1),
        .err_len (err_len),
        .err_hdr (err_hdr)
    );

    function automatic out_t sample();
        out_t o;
        o.ir  = in_ready;
        o.bz  = busy;
        o.y0v = y0_valid;
        o.y0d = y0_data;
        o.y0l = y0_last;
        o.y1v = y1_valid;
        o.y1d = y1_data;
        o.y1l = y1_last;
        o.c0  = pkt_cnt0;
        o.c1  = pkt_cnt1;
        o.eh  = err_hdr;
        o.el  = err_len;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic v, input logic l, input logic r0,
                       input logic r1, input logic ir, input logic bz, input logic y0v,
                       input logic [7:0] y0d, input logic y0l, input logic y1v,
                       input logic [7:0] y1d, input logic y1l, input logic [7:0] c0,
                       input logic [7:0] c1, input logic eh, input logic el);
        vec_t t;
        t.d = d; t.v = v; t.l = l; t.r0 = r0; t.r1 = r1;
        t.exp = '{ir: ir, bz: bz, y0v: y0v, y0d: y0d, y0l: y0l, y1v: y1v, y1d: y1d, y1l: y1l,
                  c0: c0, c1: c1, eh: eh, el: el};
        vecs.push_back(t);
    endtask

    initial begin
        out_t zero;
        out_t a;
        zero = '0;

        //   d      v  l  r0 r1 | ir bz y0v y0d    y0l y1v y1d    y1l c0 c1 eh el
        // Header 0x01, payload A1 A2 A3 to channel 1
        add(8'h01, 1, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(8'hA1, 1, 0, 1, 1,   1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(8'hA2, 1, 0, 1, 1,   1, 1, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 0);
        add(8'hA3, 1, 1, 1, 1,   1, 1, 0, 8'h00, 0, 1, 8'hA2, 0, 0, 0, 0, 0);
        add(8'h00, 0, 0, 1, 1,   1, 1, 0, 8'h00, 0, 1, 8'hA3, 1, 0, 0, 0, 0);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        // Header 0x00, payload 11 22, y0_ready low three cycles
        add(8'h00, 1, 0, 0, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h11, 1, 0, 0, 1,   1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h22, 1, 1, 0, 1,   0, 1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h22, 1, 1, 0, 1,   0, 1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h22, 1, 1, 0, 1,   0, 1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h22, 1, 1, 1, 1,   1, 1, 1, 8'h11, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 1, 1,   1, 1, 1, 8'h22, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        // Header-only packet
        add(8'h02, 1, 1, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 1, 0);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        // Over-length: 6 payload beats with MAX_LEN=4
        add(8'h00, 1, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'hB1, 1, 0, 1, 1,   1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'hB2, 1, 0, 1, 1,   1, 1, 1, 8'hB1, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'hB3, 1, 0, 1, 1,   1, 1, 1, 8'hB2, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'hB4, 1, 0, 1, 1,   1, 1, 1, 8'hB3, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(8'hB5, 1, 0, 1, 1,   1, 1, 1, 8'hB4, 1, 0, 8'h00, 0, 1, 1, 0, 1);
        add(8'hB6, 1, 1, 1, 1,   1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 0, 1);
        // Back-to-back: 0x55 on ch0 held while next header arrives, then 0x66 on ch1
        add(8'h00, 1, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h55, 1, 1, 1, 1,   1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h01, 1, 0, 0, 1,   1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h66, 1, 1, 0, 1,   0, 1, 1, 8'h55, 1, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h66, 1, 1, 1, 1,   1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 2, 1, 0, 1);
        add(8'h00, 0, 0, 1, 0,   1, 1, 0, 8'h00, 0, 1, 8'h66, 1, 3, 1, 0, 1);
        add(8'h00, 0, 0, 1, 1,   1, 1, 0, 8'h00, 0, 1, 8'h66, 1, 3, 1, 0, 1);
        add(8'h00, 0, 0, 1, 1,   1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3, 2, 0, 1);

        // Reset state
        @(posedge clk);
        #1;
        check("reset_state", 64'(sample()), 64'(zero));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            in_data  = vecs[i].d;
            in_valid = vecs[i].v;
            in_last  = vecs[i].l;
            y0_ready = vecs[i].r0;
            y1_ready = vecs[i].r1;
            @(negedge clk);
            a = sample();
            if (a !== vecs[i].exp) begin
                n_checks++;
                n_fail++;
                $display("FAIL vec%0d: got %h, expected %h", i, a, vecs[i].exp);
            end else begin
                n_checks++;
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted during the 2nd payload beat of a 4-beat channel-1 packet
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        in_data  = 8'h01; in_valid = 1'b1; in_last = 1'b0;
        @(posedge clk);
        #1;
        in_data = 8'hC1;
        @(posedge clk);
        #1;
        in_data = 8'hC2;
        #1;
        check("pre_rst_y1_data", 64'(y1_data), 64'(8'hC1));
        check("pre_rst_busy", 64'(busy), 64'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        check("rst_outputs_zero", 64'(sample()), 64'(zero));
        @(negedge clk);
        check("rst_in_ready_low", 64'(in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle_ready", 64'({in_ready, busy}), 64'(2'b10));
        @(posedge clk);
        #1;
        in_data = 8'h01; in_valid = 1'b1; in_last = 1'b0;
        @(posedge clk);
        #1;
        in_data = 8'hD1; in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(negedge clk);
        check("post_rst_y1", 64'({y1_valid, y1_data, y1_last, y0_valid}),
              64'({1'b1, 8'hD1, 1'b1, 1'b0}));
        check("post_rst_cnt_before", 64'({pkt_cnt0, pkt_cnt1}), 64'(16'h0000));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_cnt1", 64'({pkt_cnt0, pkt_cnt1, y1_valid}), 64'({8'h00, 8'h01, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_pkt_router.md
Name: demux_pkt_router

Overview:
- Sequential, packet-level front end for the 1-to-2 demultiplexer function.
- Accepts a valid/ready byte stream whose first beat of every packet is a header. Header bit 0 latches the destination select.
- Forwards payload beats through a single output register to one of two valid/ready output channels. Only the selected channel sees valid and data; the other channel sees zeros.
- Sits between the packet source and two downstream consumers; keeps per-output packet counts and error flags.

Parameters:
- DATA_W, 8, width of the data beat (header and payload).
- CNT_W, 8, width of each per-output packet counter.
- MAX_LEN, 16, maximum payload beats per packet (excludes header); legal range 1..2^16-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  stream data beat.
- in_valid  input  1  stream beat valid.
- in_last  input  1  marks final beat of a packet.
- in_ready  output  1  block accepts the beat this cycle.
- y0_data  output  DATA_W  channel 0 data; 0 when channel 0 is not valid.
- y0_valid  output  1  channel 0 beat valid.
- y0_last  output  1  channel 0 end of packet.
- y0_ready  input  1  channel 0 consumer ready.
- y1_data, y1_valid, y1_last, y1_ready: same as the channel 0 ports, for channel 1.
- busy  output  1  high when the FSM is not IDLE or the output register is valid.
- pkt_cnt0  output  CNT_W  completed packets delivered on channel 0.
- pkt_cnt1  output  CNT_W  completed packets delivered on channel 1.
- err_len  output  1  sticky flag: a packet exceeded MAX_LEN.
- err_hdr  output  1  one-cycle pulse: header-only packet received.

Behaviour:
- Reset:
  - The interface is one clock; reset is asynchronous and active-high.
  - On reset: state=IDLE; output register valid/last/sel/data = 0; counters = 0; err_len = 0; err_hdr = 0; len = 0.
  - in_ready is forced 0 while rst is high.
  - Reset asserted mid-packet drops the packet in flight; no partial count is kept.
- Handshake:
  - A beat transfers when valid && ready are both high at a rising edge.
  - Outputs obey the rule that once y*_valid rises, it holds with stable data/last until the matching y*_ready is seen.
- Output register: out_valid, out_data, out_last, out_sel.
  - y0_valid = out_valid & ~out_sel; y1_valid = out_valid & out_sel.
  - y*_data and y*_last are ANDed with their own valid.
  - out_sel is captured at load, so a new header may change the FSM select while the last beat of the prior packet is still held.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On header transfer: sel <= in_data[0]; len <= 0.
    - If in_last is also high: err_hdr pulses next cycle and the FSM stays in IDLE (packet dropped, not counted).
    - Otherwise go to ROUTE.
  - ROUTE:
    - in_ready = ~out_valid | out_ready_of(out_sel), giving full throughput.
    - On transfer: load the output register with data=in_data, sel=sel, last = in_last | (len==MAX_LEN-1); then len++.
    - If in_last: go to IDLE.
    - Else if len==MAX_LEN-1: set err_len and go to DISCARD (the truncated packet is emitted with last=1).
  - DISCARD:
    - in_ready = 1; beats are dropped.
    - The beat with in_last returns the FSM to IDLE.
- Latency: a payload beat accepted at edge N is visible on y*_valid after edge N, i.e. one cycle. Headers are never forwarded.
- Counters:
  - pkt_cntX increments when out_valid & out_last & yX_ready with out_sel==X.
  - Counters wrap modulo 2^CNT_W.
- Simultaneous events: an output drain and a new load in the same cycle replace the register content with no bubble. Counting of the drained beat is unaffected.
- Exactly MAX_LEN payload beats with in_last on the final beat: a normal packet; no error and no DISCARD.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, ROUTE, DISCARD, 2-bit encoding);
  - the header select bit index constant (0);
  - default width constants.
- One natural sub-module, demux_out_reg: a one-entry output register plus the 1-to-2 valid/data steering with zero gating of the unselected channel.

Test Plan:
- Header 0x01 followed by payload 0xA1, 0xA2, 0xA3 (last on 0xA3), both readys high:
  - y1 shows A1, A2, A3 on consecutive cycles, last on A3;
  - y0_valid stays 0 and y0_data stays 0;
  - pkt_cnt1 = 1.
- Header 0x00, payload 0x11, 0x22 (last), with y0_ready held low for 3 cycles:
  - y0 holds 0x11 stable;
  - in_ready = 0 while the register is full;
  - after release, 0x11 then 0x22 is delivered; pkt_cnt0 = 1.
- Header 0x02 with in_last=1:
  - err_hdr pulses exactly 1 cycle;
  - no output valid; counters unchanged.
- MAX_LEN=4, 6-beat payload to channel 0:
  - 4 beats emitted, the 4th with last=1;
  - beats 5 and 6 dropped; err_len = 1 (sticky); pkt_cnt0 = 1.
- Back-to-back packets: header 0x00 + 0x55 (last), then header 0x01 + 0x66 (last), with y0_ready low during the second header:
  - 0x55 stays on y0 and 0x66 later appears on y1;
  - pkt_cnt0 = 1, pkt_cnt1 = 1.
- Assert rst during the 2nd payload beat of a 4-beat packet:
  - all outputs go to 0 immediately; in_ready = 0 while rst is high;
  - after release, the FSM is in IDLE and the next header is routed correctly.
